// File: rtl/uart_hex_parse_pkg.sv
// Shared definitions for the UART receive path: ASCII codes, parser and
// receiver state encodings, and the character-class payload.
package uart_hex_parse_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIGITS  = 2'd1,
    S_DISCARD = 2'd2
  } parse_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Result of classifying one received character
  typedef struct packed {
    logic       is_digit;
    logic       is_term;
    logic       is_space;
    logic [3:0] nibble;
  } char_class_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, falling-edge start detect, half-bit
// start re-check, centre sampling, and a byte_ready / frame_err strobe.
module uart_rx
  import uart_hex_parse_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 200000000,
  parameter int unsigned BAUD_RATE       = 9600
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       byte_ready,
  output logic       frame_err
);

  localparam int unsigned BIT_CLKS  = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int unsigned HALF_CLKS = BIT_CLKS / 2;
  localparam int unsigned CNT_W     = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CLKS - 1);

  logic             sync1;
  logic             sync2;
  logic             prev;
  rx_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;

  // Synchronizer and edge-detect flops are preset high so release never fakes a start edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      prev       <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      dout       <= '0;
      byte_ready <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync1      <= rx;
      sync2      <= sync1;
      prev       <= sync2;
      byte_ready <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (prev && !sync2) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (sync2) begin
              state <= RX_IDLE;
            end else begin
              state   <= RX_DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            dout    <= {sync2, dout[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            state      <= RX_IDLE;
            byte_ready <= sync2;
            frame_err  <= !sync2;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_hex_parse.sv
// Parses fixed-length hex fields terminated by CR/LF from the UART RX line
// into a binary value with one-cycle valid / error strobes.
module uart_hex_parse
  import uart_hex_parse_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 200000000,
  parameter int unsigned BAUD_RATE       = 9600,
  parameter int unsigned DIGITS          = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                rx,
  output logic [4*DIGITS-1:0] dout,
  output logic                valid,
  output logic                error
);

  localparam int unsigned W     = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DIGITS);

  logic [7:0]       rx_byte;
  logic             byte_ready;
  logic             frame_err;
  char_class_t      cls;
  parse_state_e     state;
  logic [W-1:0]     acc;
  logic [CNT_W-1:0] count;

  uart_rx #(
    .CLOCK_FREQUENCY(CLOCK_FREQUENCY),
    .BAUD_RATE      (BAUD_RATE)
  ) u_rx (
    .clk       (clk),
    .resetn    (resetn),
    .rx        (rx),
    .dout      (rx_byte),
    .byte_ready(byte_ready),
    .frame_err (frame_err)
  );

  // ASCII to nibble classifier
  always_comb begin
    cls = '0;
    if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
      cls.is_digit = 1'b1;
      cls.nibble   = rx_byte[3:0];
    end else if ((rx_byte >= 8'h41 && rx_byte <= 8'h46) ||
                 (rx_byte >= 8'h61 && rx_byte <= 8'h66)) begin
      cls.is_digit = 1'b1;
      cls.nibble   = rx_byte[3:0] + 4'd9;
    end else if (rx_byte == ASCII_CR || rx_byte == ASCII_LF) begin
      cls.is_term = 1'b1;
    end else if (rx_byte == ASCII_SPACE) begin
      cls.is_space = 1'b1;
    end
  end

  // Field parser; a frame error behaves like an invalid character
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      acc   <= '0;
      count <= '0;
      dout  <= '0;
      valid <= 1'b0;
      error <= 1'b0;
    end else begin
      valid <= 1'b0;
      error <= 1'b0;
      if (frame_err) begin
        if (state != S_DISCARD) begin
          error <= 1'b1;
          state <= S_DISCARD;
        end
      end else if (byte_ready && !cls.is_space) begin
        case (state)
          S_IDLE: begin
            if (cls.is_digit) begin
              acc   <= W'(cls.nibble);
              count <= CNT_W'(1);
              state <= S_DIGITS;
            end else if (!cls.is_term) begin
              error <= 1'b1;
              state <= S_DISCARD;
            end
          end
          S_DIGITS: begin
            if (cls.is_digit) begin
              if (count == FULL) begin
                error <= 1'b1;
                state <= S_DISCARD;
              end else begin
                acc   <= W'({acc, cls.nibble});
                count <= count + CNT_W'(1);
              end
            end else if (cls.is_term) begin
              if (count == FULL) begin
                dout  <= acc;
                valid <= 1'b1;
              end else begin
                error <= 1'b1;
              end
              state <= S_IDLE;
              acc   <= '0;
              count <= '0;
            end else begin
              error <= 1'b1;
              state <= S_DISCARD;
            end
          end
          S_DISCARD: begin
            if (cls.is_term) begin
              state <= S_IDLE;
              acc   <= '0;
              count <= '0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_hex_parse.sv
// Bench for uart_hex_parse: directed vector table, reset/glitch sequences,
// and a randomized character stream checked against a field-level model.
module tb_uart_hex_parse;

  localparam int unsigned CLKF   = 1000000;
  localparam int unsigned BAUD   = 100000;
  localparam int unsigned NDIG   = 2;
  localparam int          BITCLK = 10;
  localparam int          GAP    = 2;
  localparam logic [7:0]  CR     = 8'h0D;
  localparam logic [7:0]  LF     = 8'h0A;
  localparam logic [7:0]  SP     = 8'h20;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] dout;
  logic       valid;
  logic       error;

  int tests = 0;
  int fails = 0;
  int valid_cnt = 0;
  int error_cnt = 0;
  int both_cnt = 0;
  int ev_q[$];
  int exp_q[$];

  int   m_n;
  int   m_val;
  bit   m_bad;

  typedef struct {
    logic [63:0] txt;
    int          len;
    int          ferr_idx;
    int          exp_valid;
    int          exp_error;
    logic [7:0]  exp_dout;
  } vec_t;

  uart_hex_parse #(
    .CLOCK_FREQUENCY(CLKF),
    .BAUD_RATE      (BAUD),
    .DIGITS         (NDIG)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .rx    (rx),
    .dout  (dout),
    .valid (valid),
    .error (error)
  );

  always #5 clk = ~clk;

  // Record output strobes away from the active edge
  always @(negedge clk) begin
    if (valid && error) both_cnt++;
    if (valid) begin
      valid_cnt++;
      ev_q.push_back(int'(dout));
    end
    if (error) begin
      error_cnt++;
      ev_q.push_back(-1);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [63:0] t, input int l, input int fi,
                              input int ev, input int ee, input logic [7:0] ed);
    vec_t v;
    v.txt = t; v.len = l; v.ferr_idx = fi;
    v.exp_valid = ev; v.exp_error = ee; v.exp_dout = ed;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BITCLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BITCLK) @(negedge clk);
    end
    rx = stop;
    repeat (BITCLK) @(negedge clk);
    rx = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  function automatic int hexval(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  // Field-level reference: a field is NDIG hex digits then CR/LF; spaces vanish
  function automatic void model_char(input logic [7:0] c, input bit fe);
    int d;
    d = hexval(c);
    if (m_bad) begin
      if (!fe && (c == CR || c == LF)) begin
        m_bad = 1'b0; m_n = 0; m_val = 0;
      end
    end else if (fe) begin
      exp_q.push_back(-1); m_bad = 1'b1;
    end else if (c == SP) begin
      m_bad = 1'b0;
    end else if (d >= 0) begin
      if (m_n == int'(NDIG)) begin
        exp_q.push_back(-1); m_bad = 1'b1;
      end else begin
        m_val = m_val * 16 + d; m_n++;
      end
    end else if (c == CR || c == LF) begin
      if (m_n == int'(NDIG)) exp_q.push_back(m_val);
      else if (m_n > 0) exp_q.push_back(-1);
      m_n = 0; m_val = 0;
    end else begin
      exp_q.push_back(-1); m_bad = 1'b1;
    end
  endfunction

  initial begin
    vec_t       vec [12];
    int         v0, e0;
    logic [7:0] ch;
    logic [7:0] sq[$];
    bit         fq[$];
    logic [7:0] bad_chars [10];
    string      hexchars;
    int         nd;

    vec[0]  = mk({"3A", CR, LF},    4, -1, 1, 0, 8'h3A);
    vec[1]  = mk({"fF", CR},        3, -1, 1, 0, 8'hFF);
    vec[2]  = mk({" 0 7", LF},      5, -1, 1, 0, 8'h07);
    vec[3]  = mk({"3", CR},         2, -1, 0, 1, 8'h07);
    vec[4]  = mk({"1G2", CR},       4, -1, 0, 1, 8'h07);
    vec[5]  = mk({"123", CR},       4, -1, 0, 1, 8'h07);
    vec[6]  = mk({"42", LF},        3, -1, 1, 0, 8'h42);
    vec[7]  = mk({"A17", CR},       4,  1, 0, 1, 8'h42);
    vec[8]  = mk({"Z9", CR},        3, -1, 0, 1, 8'h42);
    vec[9]  = mk({"b0", CR},        3, -1, 1, 0, 8'hB0);
    vec[10] = mk({CR, LF, CR},      3, -1, 0, 0, 8'hB0);
    vec[11] = mk({"1 2 3", CR},     6, -1, 0, 1, 8'hB0);

    bad_chars = '{8'h2F, 8'h3A, 8'h40, 8'h47, 8'h60, 8'h67, 8'h00, 8'h7F, 8'h78, 8'h21};
    hexchars  = "0123456789ABCDEFabcdef";

    // Reset state
    #1 resetn = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_dout", int'(dout), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_error", int'(error), 0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      v0 = valid_cnt;
      e0 = error_cnt;
      for (int k = 0; k < vec[i].len; k++) begin
        ch = vec[i].txt[8*(vec[i].len-1-k) +: 8];
        send_byte(ch, (k == vec[i].ferr_idx) ? 1'b0 : 1'b1);
      end
      repeat (5) @(negedge clk);
      check($sformatf("vec%0d_valid", i), valid_cnt - v0, vec[i].exp_valid);
      check($sformatf("vec%0d_error", i), error_cnt - e0, vec[i].exp_error);
      check($sformatf("vec%0d_dout", i), int'(dout), int'(vec[i].exp_dout));
    end

    // Short low glitch on an idle line must not produce a byte
    v0 = valid_cnt;
    e0 = error_cnt;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (150) @(negedge clk);
    check("glitch_valid", valid_cnt - v0, 0);
    check("glitch_error", error_cnt - e0, 0);

    // Reset in the 4th data bit of '5' after a pending "A"
    send_byte("A", 1'b1);
    rx = 1'b0;
    repeat (BITCLK) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = 8'h35 >> i;
      repeat (BITCLK) @(negedge clk);
    end
    rx = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    repeat (5) @(negedge clk);
    check("midbyte_reset_dout", int'(dout), 0);
    rx = 1'b1;
    resetn = 1'b1;
    v0 = valid_cnt;
    e0 = error_cnt;
    repeat (30) @(negedge clk);
    send_byte("5", 1'b1);
    send_byte("C", 1'b1);
    send_byte(CR, 1'b1);
    repeat (5) @(negedge clk);
    check("post_reset_valid", valid_cnt - v0, 1);
    check("post_reset_error", error_cnt - e0, 0);
    check("post_reset_dout", int'(dout), 8'h5C);

    // Randomized field stream against the reference model
    ev_q.delete();
    exp_q.delete();
    m_n = 0; m_val = 0; m_bad = 1'b0;
    for (int f = 0; f < 45; f++) begin
      nd = (($urandom_range(0, 99) < 60) ? int'(NDIG) : int'($urandom_range(0, 3)));
      for (int k = 0; k < nd; k++) begin
        if ($urandom_range(0, 99) < 20) begin sq.push_back(SP); fq.push_back(1'b0); end
        if ($urandom_range(0, 99) < 6) begin
          sq.push_back(bad_chars[$urandom_range(0, 9)]); fq.push_back(1'b0);
        end
        if ($urandom_range(0, 99) < 5) begin
          sq.push_back(8'($urandom_range(0, 255))); fq.push_back(1'b1);
        end
        sq.push_back(hexchars[$urandom_range(0, 21)]); fq.push_back(1'b0);
      end
      sq.push_back(($urandom_range(0, 1) == 1) ? CR : LF); fq.push_back(1'b0);
      if ($urandom_range(0, 99) < 25) begin sq.push_back(LF); fq.push_back(1'b0); end
    end
    for (int i = 0; i < sq.size(); i++) begin
      model_char(sq[i], fq[i]);
      send_byte(sq[i], !fq[i]);
    end
    repeat (20) @(negedge clk);
    check("rand_event_count", ev_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
      check($sformatf("rand_event%0d", i), ev_q[i], exp_q[i]);

    check("valid_error_overlap", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
